// File: rtl/load_store_unit.sv
// Load/store initiator for a word-addressed data memory: B/H/W loads with extension, sub-word stores via read-modify-write.
// Latency: load/word store 2 cycles to response, sub-word store 3, rejected request 1; one op in flight.
// Backpressure: response held in RESP until resp_ready; req_ready only in IDLE. Option: LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int MEM_WORDS = 64,
    parameter int AW        = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_data,
    output logic          resp_err,
    output logic          mem_write,
    output logic          mem_read,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, state_nxt;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [31:0] r_wdata;

    logic        f3_ok;
    logic        req_err;
    logic [1:0]  req_off;
    logic        word_op;
    logic [4:0]  shift;
    logic [31:0] lane;
    logic [31:0] load_val;
    logic [31:0] mask;
    logic [31:0] merged;

    // Address bits above the word index wrap and are deliberately ignored.
    logic unused_ok;
    assign unused_ok = &{1'b0, req_addr[31:AW+2], MEM_WORDS[0]};

    assign word_op = (req_funct3[1:0] == 2'b10);

    always_comb begin
        f3_ok = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !req_write;
            default:                f3_ok = 1'b0;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        req_err = !f3_ok
                  || ((req_funct3[1:0] == 2'b01) && req_addr[0])
                  || (word_op && (req_addr[1:0] != 2'b00));
`else
        req_err = !f3_ok;
`endif
        // Misaligned halfword/word accesses are aligned down to their natural boundary.
        req_off = req_addr[1:0];
        if (req_funct3[1:0] == 2'b01)
            req_off = {req_addr[1], 1'b0};
        else if (word_op)
            req_off = 2'b00;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_nxt = RESP;
                    else if (req_write && word_op)
                        state_nxt = WRITE;
                    else
                        state_nxt = READ;
                end
            end
            READ:    state_nxt = r_write ? WRITE : RESP;
            WRITE:   state_nxt = RESP;
            RESP:    state_nxt = resp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shift = {r_off, 3'b000};
        lane  = mem_rdata >> shift;
        case (r_funct3)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'h0, lane[7:0]};
            3'b101:  load_val = {16'h0, lane[15:0]};
            default: load_val = mem_rdata;
        endcase
        mask   = ((r_funct3[1:0] == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << shift;
        merged = (mem_rdata & ~mask) | ((r_wdata << shift) & mask);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            r_write   <= 1'b0;
            r_funct3  <= 3'b000;
            r_off     <= 2'b00;
            r_wdata   <= 32'h0;
            resp_data <= 32'h0;
            resp_err  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                r_write   <= req_write;
                r_funct3  <= req_funct3;
                r_off     <= req_off;
                r_wdata   <= req_wdata;
                resp_data <= 32'h0;
                resp_err  <= req_err;
                // Memory-side registers move only for requests that will access memory.
                if (!req_err) begin
                    mem_addr <= req_addr[AW+1:2];
                    if (req_write && word_op)
                        mem_wdata <= req_wdata;
                end
            end
            if (state == READ) begin
                if (r_write)
                    mem_wdata <= merged;
                else
                    resp_data <= load_val;
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign mem_read   = (state == READ);
    assign mem_write  = (state == WRITE);

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a byte-array memory model.
module tb_load_store_unit;

    localparam int AW = 6;
    localparam int MEM_WORDS = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [2:0]    req_funct3 = 3'b000;
    logic [31:0]   req_addr = 32'h0;
    logic [31:0]   req_wdata = 32'h0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [31:0]   resp_data;
    logic          resp_err;
    logic          mem_write;
    logic          mem_read;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0] mem   [0:MEM_WORDS-1];
    logic [7:0]  ref_b [0:4*MEM_WORDS-1];

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.MEM_WORDS(MEM_WORDS), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int wa);
        return {ref_b[4*wa+3], ref_b[4*wa+2], ref_b[4*wa+1], ref_b[4*wa]};
    endfunction

    task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int hold);
        logic          e_err;
        logic [31:0]   e_rd, e_wdata, got_wdata;
        logic [AW-1:0] e_addr, got_addr;
        int size, base, e_lat, e_nrd, e_nwr, lat, nrd, nwr;

        // Reference: byte-granular memory, natural alignment, RV32I extension rules.
        size   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        e_err  = (f3 == 3'b011) || (f3 >= 3'b110) || (w && f3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((int'(a[7:0]) % size) != 0) e_err = 1'b1;
`endif
        base    = (int'(a[7:0]) / size) * size;
        e_addr  = AW'(base / 4);
        e_rd    = 32'h0;
        e_wdata = 32'h0;
        e_lat   = 0;
        e_nrd   = 0;
        e_nwr   = 0;
        if (!e_err) begin
            if (!w) begin
                for (int k = 0; k < size; k++) e_rd = e_rd | (32'(ref_b[base+k]) << (8*k));
                if (!f3[2] && size < 4 && e_rd[8*size-1]) e_rd = e_rd | (32'hFFFF_FFFF << (8*size));
                e_lat = 1;
                e_nrd = 1;
            end else begin
                for (int k = 0; k < size; k++) ref_b[base+k] = wd[8*k +: 8];
                e_wdata = ref_word(base / 4);
                e_nwr   = 1;
                e_nrd   = (size < 4) ? 1 : 0;
                e_lat   = (size < 4) ? 2 : 1;
            end
        end

        chk("req_ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;

        lat = 0; nrd = 0; nwr = 0; got_addr = '0; got_wdata = 32'h0;
        while (!resp_valid && lat < 16) begin
            chk("strobe_excl", mem_read & mem_write, 0);
            chk("req_ready_busy", req_ready, 0);
            if (mem_read) nrd++;
            if (mem_write) begin nwr++; got_wdata = mem_wdata; end
            if (mem_read || mem_write) got_addr = mem_addr;
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, e_lat);
        chk("read_cycles", nrd, e_nrd);
        chk("write_cycles", nwr, e_nwr);
        if (e_nrd + e_nwr > 0) chk("mem_addr", got_addr, e_addr);
        if (e_nwr > 0) chk("mem_wdata", got_wdata, e_wdata);

        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", resp_valid, 1);
            chk("hold_data", resp_data, e_rd);
            chk("hold_ready", req_ready, 0);
            chk("hold_strobes", {mem_read, mem_write}, 0);
            @(posedge clk); #1;
        end
        chk("resp_data", resp_data, e_rd);
        chk("resp_err", resp_err, e_err);
        resp_ready = 1'b1;
        #1;
        chk("no_overlap", req_ready, 0);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_drop", resp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            w0 = $urandom;
            mem[i] = w0;
            for (int k = 0; k < 4; k++) ref_b[4*i+k] = w0[8*k +: 8];
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        run_op(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0);   // SW
        run_op(1'b0, 3'b010, 32'h10, 32'h0, 0);           // LW
        run_op(1'b1, 3'b000, 32'h11, 32'h0000_005A, 0);   // SB merge
        run_op(1'b0, 3'b000, 32'h11, 32'h0, 0);           // LB
        run_op(1'b0, 3'b100, 32'h13, 32'h0, 0);           // LBU
        run_op(1'b0, 3'b001, 32'h12, 32'h0, 0);           // LH
        run_op(1'b0, 3'b010, 32'h10, 32'h0, 5);           // backpressure
        run_op(1'b0, 3'b010, 32'h12, 32'h0, 0);           // misaligned LW
        run_op(1'b1, 3'b011, 32'h14, 32'h1234_5678, 0);   // invalid store
        run_op(1'b1, 3'b001, 32'h17, 32'hABCD_8765, 0);   // SH odd address
        run_op(1'b0, 3'b101, 32'h16, 32'h0, 0);           // LHU
        run_op(1'b1, 3'b100, 32'h18, 32'h0, 0);           // store with load-only code
        run_op(1'b1, 3'b010, 32'h20, 32'h1122_3344, 0);

        // Reset during WRITE: the store must be dropped.
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstmid_write_hi", mem_write, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("rstmid_write_lo", mem_write, 0);
        chk("rstmid_resp_valid", resp_valid, 0);
        chk("rstmid_mem_addr", mem_addr, 0);
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_req_ready", req_ready, 1);
        chk("rstmid_mem_kept", mem[8], ref_word(8));

        for (int n = 0; n < 250; n++) begin
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                   $urandom, $urandom_range(0, 2));
        end

        for (int i = 0; i < MEM_WORDS; i++) chk("final_mem", mem[i], ref_word(i));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the word-addressed data-memory interface: accepts one load/store request at a time from the CPU datapath and drives the memory's write-enable, read-enable, word address and write data. Handles RV32I byte/halfword/word widths: sign/zero extension on loads, read-modify-write merging on sub-word stores. It sits between the execute stage and the data memory, the only master of that memory.

## Interface
- MEM_WORDS, 64, memory depth in 32-bit words
- AW, 6, word-address width (log2 MEM_WORDS)

- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_data  out  32  extended load data; 0 for stores
- resp_err  out  1  request rejected; no memory access performed
- mem_write  out  1  memory write enable
- mem_read  out  1  memory read enable
- mem_addr  out  AW  word address = req_addr[AW+1:2]; upper bits ignored (wrap)
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, combinational from mem_addr when mem_read=1

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, capture all request fields. Next state:
  - error (see below) -> RESP with resp_err=1;
  - load -> READ; word store -> WRITE; byte/half store -> READ.
- READ: mem_read=1, mem_addr driven. At the edge:
  - load: lane selected by addr[1:0] (little-endian, lane 0 = bits 7:0); B/H sign-extend, BU/HU zero-extend, W unchanged; register into resp_data; -> RESP.
  - sub-word store: merge req_wdata[7:0] or [15:0] into mem_rdata at the addressed lane, register the merged word; -> WRITE.
- WRITE: mem_write=1, mem_wdata = req_wdata (word) or merged word; -> RESP.
- RESP: resp_valid=1, resp_data/resp_err held stable until resp_ready=1; then -> IDLE, clearing resp_valid.
- mem_read and mem_write never both high; both 0 outside READ/WRITE. mem_addr/mem_wdata hold last value when idle.
- Errors: funct3 011, 110, 111 (or 100/101 with req_write=1) always yield resp_err=1, no access.

## Timing
- Request accepted at edge E0 (IDLE, req_valid=1).
- Load / word store: resp_valid high from E1+ (first RESP cycle after one access cycle); minimum 3 cycles request-to-next-accept.
- Sub-word store: READ at cycle after E0, WRITE next, resp_valid after E2; min 4 cycles per op.
- Error: resp_valid the cycle after E0.
- Response and new request never overlap in one cycle; req_ready=0 during RESP even if resp_ready=1.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- reset_n asserted mid-operation: immediate return to IDLE, outputs to reset values, in-flight op dropped; a pending WRITE is not performed.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]≠0, return resp_err=1 with no memory access.
- Undefined: misaligned addresses are silently aligned down (H: addr[0] forced 0; W: addr[1:0] forced 0) and executed normally; resp_err only for invalid funct3.

## Test plan
- Reset: reset_n=0 mid-WRITE -> mem_write drops immediately, resp_valid=0, req_ready=1 after release; memory word unchanged.
- SW 0xDEADBEEF to addr 0x10, then LW 0x10 -> mem_addr=4, mem_write pulses one cycle, load resp_data=0xDEADBEEF, resp_err=0.
- SB 0x5A to addr 0x11 over word 0xDEADBEEF -> READ then WRITE, mem_wdata=0xDEAD5AEF; LB 0x11 -> 0x0000005A; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD.
- Backpressure: resp_ready=0 for 5 cycles after load -> resp_valid, resp_data stable, req_ready=0, no memory strobes; accepted on first resp_ready=1.
- LW at addr 0x12: with LSU_MISALIGN_TRAP_EN -> resp_err=1, mem_read never high; without -> reads word at 0x10.
- funct3=011 store -> resp_err=1 one cycle after accept, mem_write never high.
